ex_pipe: RTL and testbench

Execute-side partner of the decode stage: latches the decoded operation (`aluop`, `alusel`, `reg1`, `reg2`, `wd`, `wreg`) in an ID/EX register and computes the ALU result. It drives the EX-stage forwarding bus back to decode and registers the result into an EX/MEM register for the memory stage. It sits between `id` and `mem` in the 5-stage RV32I pipeline and honours the central stall/flush controls.

---
 rtl/ex_pipe.sv | 148 ++++++++++++++
 tb/tb_ex_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_pipe.sv
// ex_pipe: ID/EX register, RV32I integer ALU, EX forwarding bus and EX/MEM register.
// Sits between decode and memory stages and obeys the central stall/flush controls.
module ex_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  id_aluop_i,
  input  logic [2:0]  id_alusel_i,
  input  logic [31:0] id_reg1_i,
  input  logic [31:0] id_reg2_i,
  input  logic [4:0]  id_wd_i,
  input  logic        id_wreg_i,
  input  logic        id_stall_i,
  input  logic        ex_stall_i,
  input  logic        mem_stall_i,
  input  logic        flush_i,
  output logic        ex_wreg_o,
  output logic [4:0]  ex_wd_o,
  output logic [31:0] ex_wdata_o,
  output logic        mem_wreg_o,
  output logic [4:0]  mem_wd_o,
  output logic [31:0] mem_wdata_o
);

  // Operation encodings shared with the decode stage.
  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
  localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
  localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;

  localparam logic [2:0] EXE_RES_NOP        = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
  } idex_t;

  typedef struct packed {
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
  } exmem_t;

  localparam idex_t IDEX_BUBBLE = '{aluop: EXE_NOP_OP, alusel: EXE_RES_NOP,
                                    reg1: 32'd0, reg2: 32'd0, wd: 5'd0, wreg: 1'b0};
  localparam exmem_t EXMEM_CLEAR = '{wreg: 1'b0, wd: 5'd0, wdata: 32'd0};

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;

  logic [31:0] logic_res, shift_res, arith_res, result;
  logic [4:0]  shamt;

  // ID/EX next state: flush, then bubble-on-ID-stall, then load, else hold.
  always_comb begin
    // NOTE: assign a default first so every path drives the signal; otherwise a latch is inferred.
    idex_d = idex_q;
    if (flush_i) begin
      idex_d = IDEX_BUBBLE;
    end else if (id_stall_i && !ex_stall_i) begin
      idex_d = IDEX_BUBBLE;
    end else if (!id_stall_i) begin
      idex_d = '{aluop: id_aluop_i, alusel: id_alusel_i, reg1: id_reg1_i,
                 reg2: id_reg2_i, wd: id_wd_i, wreg: id_wreg_i};
    end
  end

  // ID/EX register; reset loads a bubble without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep register updates order-independent across always_ff blocks.
    if (rst) idex_q <= IDEX_BUBBLE;
    else     idex_q <= idex_d;
  end

  assign shamt = idex_q.reg2[4:0];

  // ALU: one result per class; any operation not belonging to the class yields 0.
  always_comb begin
    logic_res = 32'd0;
    shift_res = 32'd0;
    arith_res = 32'd0;
    case (idex_q.aluop)
      EXE_OR_OP:   logic_res = idex_q.reg1 | idex_q.reg2;
      EXE_AND_OP:  logic_res = idex_q.reg1 & idex_q.reg2;
      EXE_XOR_OP:  logic_res = idex_q.reg1 ^ idex_q.reg2;
      EXE_SLL_OP:  shift_res = idex_q.reg1 << shamt;
      EXE_SRL_OP:  shift_res = idex_q.reg1 >> shamt;
      EXE_SRA_OP:  shift_res = $unsigned($signed(idex_q.reg1) >>> shamt);
      EXE_ADD_OP:  arith_res = idex_q.reg1 + idex_q.reg2;
      EXE_SUB_OP:  arith_res = idex_q.reg1 - idex_q.reg2;
      EXE_SLT_OP:  arith_res = {31'd0, $signed(idex_q.reg1) < $signed(idex_q.reg2)};
      EXE_SLTU_OP: arith_res = {31'd0, idex_q.reg1 < idex_q.reg2};
      default:     ;
    endcase
  end

  // Result mux by result class; NOP and unknown classes give 0.
  always_comb begin
    result = 32'd0;
    case (idex_q.alusel)
      EXE_RES_LOGIC:      result = logic_res;
      EXE_RES_SHIFT:      result = shift_res;
      EXE_RES_ARITHMETIC: result = arith_res;
      default:            result = 32'd0;
    endcase
  end

  // Forwarding bus depends only on ID/EX state; writes to x0 are never forwarded.
  assign ex_wd_o    = idex_q.wd;
  assign ex_wdata_o = result;
  assign ex_wreg_o  = idex_q.wreg & (idex_q.wd != 5'd0);

  // EX/MEM next state: flush, then bubble-on-EX-stall, then load, else hold.
  always_comb begin
    exmem_d = exmem_q;
    if (flush_i) begin
      exmem_d = EXMEM_CLEAR;
    end else if (ex_stall_i && !mem_stall_i) begin
      exmem_d = EXMEM_CLEAR;
    end else if (!ex_stall_i) begin
      exmem_d = '{wreg: ex_wreg_o, wd: ex_wd_o, wdata: ex_wdata_o};
    end
  end

  // EX/MEM register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) exmem_q <= EXMEM_CLEAR;
    else     exmem_q <= exmem_d;
  end

  assign mem_wreg_o  = exmem_q.wreg;
  assign mem_wd_o    = exmem_q.wd;
  assign mem_wdata_o = exmem_q.wdata;

endmodule

// File: tb/tb_ex_pipe.sv
// tb_ex_pipe: scoreboard bench for ex_pipe (ALU corners, x0, stalls, flush, reset, random stream).
module tb_ex_pipe;

  localparam logic [7:0] NOP  = 8'b0000_0000;
  localparam logic [7:0] AND_ = 8'b0010_0100;
  localparam logic [7:0] OR_  = 8'b0010_0101;
  localparam logic [7:0] XOR_ = 8'b0010_0110;
  localparam logic [7:0] SLL  = 8'b0111_1100;
  localparam logic [7:0] SRL  = 8'b0000_0010;
  localparam logic [7:0] SRA  = 8'b0000_0011;
  localparam logic [7:0] ADD  = 8'b0010_0000;
  localparam logic [7:0] SUB  = 8'b0010_0010;
  localparam logic [7:0] SLT  = 8'b0010_1010;
  localparam logic [7:0] SLTU = 8'b0010_1011;
  localparam logic [2:0] S_NOP = 3'b000;
  localparam logic [2:0] S_LOG = 3'b001;
  localparam logic [2:0] S_SHF = 3'b010;
  localparam logic [2:0] S_ARI = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  id_aluop_i;
  logic [2:0]  id_alusel_i;
  logic [31:0] id_reg1_i, id_reg2_i;
  logic [4:0]  id_wd_i;
  logic        id_wreg_i;
  logic        id_stall_i, ex_stall_i, mem_stall_i, flush_i;
  logic        ex_wreg_o, mem_wreg_o;
  logic [4:0]  ex_wd_o, mem_wd_o;
  logic [31:0] ex_wdata_o, mem_wdata_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
  } exp_t;

  exp_t ex_q[$];
  exp_t mem_q[$];

  ex_pipe dut (
    .clk(clk), .rst(rst),
    .id_aluop_i(id_aluop_i), .id_alusel_i(id_alusel_i),
    .id_reg1_i(id_reg1_i), .id_reg2_i(id_reg2_i),
    .id_wd_i(id_wd_i), .id_wreg_i(id_wreg_i),
    .id_stall_i(id_stall_i), .ex_stall_i(ex_stall_i),
    .mem_stall_i(mem_stall_i), .flush_i(flush_i),
    .ex_wreg_o(ex_wreg_o), .ex_wd_o(ex_wd_o), .ex_wdata_o(ex_wdata_o),
    .mem_wreg_o(mem_wreg_o), .mem_wd_o(mem_wd_o), .mem_wdata_o(mem_wdata_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata);
    exp_t e;
    e.wreg = wreg; e.wd = wd; e.wdata = wdata;
    return e;
  endfunction

  // Independent reference: result as defined for each (class, operation) pair.
  function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [2:0] sel,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    if (sel == S_LOG && op == OR_)  return a | b;
    if (sel == S_LOG && op == AND_) return a & b;
    if (sel == S_LOG && op == XOR_) return a ^ b;
    if (sel == S_SHF && op == SLL)  return a << sh;
    if (sel == S_SHF && op == SRL)  return a >> sh;
    if (sel == S_SHF && op == SRA)  return $unsigned($signed(a) >>> sh);
    if (sel == S_ARI && op == ADD)  return a + b;
    if (sel == S_ARI && op == SUB)  return a - b;
    if (sel == S_ARI && op == SLT)  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    if (sel == S_ARI && op == SLTU) return (a < b) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  task automatic check_ex(input string tag, input exp_t e);
    check({tag, " ex_wreg"},  {31'd0, ex_wreg_o}, {31'd0, e.wreg});
    check({tag, " ex_wd"},    {27'd0, ex_wd_o},   {27'd0, e.wd});
    check({tag, " ex_wdata"}, ex_wdata_o,         e.wdata);
  endtask

  task automatic check_mem(input string tag, input exp_t e);
    check({tag, " mem_wreg"},  {31'd0, mem_wreg_o}, {31'd0, e.wreg});
    check({tag, " mem_wd"},    {27'd0, mem_wd_o},   {27'd0, e.wd});
    check({tag, " mem_wdata"}, mem_wdata_o,         e.wdata);
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] wd, input logic wreg);
    id_aluop_i = op; id_alusel_i = sel; id_reg1_i = r1; id_reg2_i = r2;
    id_wd_i = wd; id_wreg_i = wreg;
  endtask

  // Drive an instruction and push its expected forwarding values to the scoreboard.
  task automatic issue(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] res);
    drive(op, sel, r1, r2, wd, wreg);
    ex_q.push_back(mk(wreg && (wd != 5'd0), wd, res));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One unstalled edge: the oldest MEM entry and the oldest EX entry are compared.
  task automatic clock_sb(input string tag);
    exp_t e;
    tick();
    if (mem_q.size() > 0) begin
      e = mem_q.pop_front();
      check_mem(tag, e);
    end
    if (ex_q.size() > 0) begin
      e = ex_q.pop_front();
      check_ex(tag, e);
      mem_q.push_back(e);
    end
  endtask

  task automatic check_zero(input string tag);
    check_ex(tag, mk(1'b0, 5'd0, 32'd0));
    check_mem(tag, mk(1'b0, 5'd0, 32'd0));
  endtask

  logic [7:0] ops  [12] = '{ADD, SUB, SLT, SLTU, OR_, AND_, XOR_, SLL, SRL, SRA, SLT, NOP};
  logic [2:0] sels [12] = '{S_ARI, S_ARI, S_ARI, S_ARI, S_LOG, S_LOG, S_LOG, S_SHF, S_SHF, S_SHF, S_SHF, S_NOP};

  initial begin
    rst = 1'b1;
    id_stall_i = 1'b0; ex_stall_i = 1'b0; mem_stall_i = 1'b0; flush_i = 1'b0;
    drive(NOP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    #12;
    check_zero("reset");
    rst = 1'b0;

    // Basic ADD overflow wrap, then ALU corners and x0 suppression through the scoreboard.
    issue(ADD,  S_ARI, 32'h7FFF_FFFF, 32'd1,         5'd5,  1'b1, 32'h8000_0000); clock_sb("add_wrap");
    issue(SUB,  S_ARI, 32'd0,         32'd1,         5'd6,  1'b1, 32'hFFFF_FFFF); clock_sb("sub");
    issue(SRA,  S_SHF, 32'h8000_0000, 32'h0000_0024, 5'd7,  1'b1, 32'hF800_0000); clock_sb("sra");
    issue(SRL,  S_SHF, 32'h8000_0000, 32'h0000_0024, 5'd7,  1'b1, 32'h0800_0000); clock_sb("srl");
    issue(SLT,  S_ARI, 32'hFFFF_FFFF, 32'd1,         5'd8,  1'b1, 32'd1);         clock_sb("slt");
    issue(SLTU, S_ARI, 32'hFFFF_FFFF, 32'd1,         5'd8,  1'b1, 32'd0);         clock_sb("sltu");
    issue(XOR_, S_LOG, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd9,  1'b1, 32'h0F0F_F0F0); clock_sb("xor");
    issue(ADD,  S_ARI, 32'h10,        32'h2,         5'd0,  1'b1, 32'h12);        clock_sb("x0");
    issue(SLL,  S_SHF, 32'h1,         32'hFFFF_FFFF, 5'd3,  1'b1, 32'h8000_0000); clock_sb("sll31");
    issue(ADD,  S_LOG, 32'h5,         32'h5,         5'd4,  1'b1, 32'd0);         clock_sb("bad_combo");
    issue(NOP,  S_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0); clock_sb("drain");

    // Asynchronous reset between edges clears both registers immediately.
    issue(ADD, S_ARI, 32'd1, 32'd2, 5'd3, 1'b1, 32'd3); clock_sb("pre_rst_a");
    issue(OR_, S_LOG, 32'd4, 32'd1, 5'd4, 1'b1, 32'd5); clock_sb("pre_rst_b");
    #3 rst = 1'b1;
    #1 check_zero("async_rst");
    rst = 1'b0;
    ex_q.delete(); mem_q.delete();
    drive(NOP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0);

    // ID stall alone: two bubbles into EX, then the held instruction enters exactly once.
    drive(ADD, S_ARI, 32'd1, 32'd1, 5'd11, 1'b1); tick();
    check_ex("ids_x", mk(1'b1, 5'd11, 32'd2));
    drive(ADD, S_ARI, 32'd5, 32'd5, 5'd8, 1'b1); id_stall_i = 1'b1; tick();
    check_ex("ids_bub1", mk(1'b0, 5'd0, 32'd0));
    check_mem("ids_bub1", mk(1'b1, 5'd11, 32'd2));
    tick();
    check_ex("ids_bub2", mk(1'b0, 5'd0, 32'd0));
    id_stall_i = 1'b0; tick();
    check_ex("ids_enter", mk(1'b1, 5'd8, 32'd10));
    drive(NOP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0); tick();
    check_ex("ids_once", mk(1'b0, 5'd0, 32'd0));
    check_mem("ids_once", mk(1'b1, 5'd8, 32'd10));

    // Full stall for three edges, then EX-only stall bubbles MEM, then release.
    drive(XOR_, S_LOG, 32'hFF, 32'h0F, 5'd12, 1'b1); tick();
    drive(SUB, S_ARI, 32'd10, 32'd3, 5'd13, 1'b1); tick();
    drive(ADD, S_ARI, 32'h100, 32'h1, 5'd14, 1'b1);
    id_stall_i = 1'b1; ex_stall_i = 1'b1; mem_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ex("hold3", mk(1'b1, 5'd13, 32'd7));
      check_mem("hold3", mk(1'b1, 5'd12, 32'hF0));
    end
    mem_stall_i = 1'b0; tick();
    check_ex("exstall", mk(1'b1, 5'd13, 32'd7));
    check_mem("exstall", mk(1'b0, 5'd0, 32'd0));
    id_stall_i = 1'b0; ex_stall_i = 1'b0; tick();
    check_ex("release", mk(1'b1, 5'd14, 32'h101));
    check_mem("release", mk(1'b1, 5'd13, 32'd7));
    drive(NOP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0); tick();
    check_mem("release2", mk(1'b1, 5'd14, 32'h101));

    // Flush beats simultaneous stalls.
    drive(OR_, S_LOG, 32'h00F0, 32'h000F, 5'd9, 1'b1); tick();
    drive(AND_, S_LOG, 32'hF0F0, 32'hFF00, 5'd10, 1'b1); tick();
    check_ex("pre_flush", mk(1'b1, 5'd10, 32'hF000));
    check_mem("pre_flush", mk(1'b1, 5'd9, 32'hFF));
    drive(ADD, S_ARI, 32'd9, 32'd9, 5'd2, 1'b1);
    flush_i = 1'b1; id_stall_i = 1'b1; ex_stall_i = 1'b1; tick();
    check_zero("flush");
    flush_i = 1'b0; id_stall_i = 1'b0; ex_stall_i = 1'b0;
    issue(ADD, S_ARI, 32'd3, 32'd4, 5'd15, 1'b1, 32'd7); clock_sb("post_flush");
    issue(NOP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);  clock_sb("post_flush");

    // Back-to-back random stream against the reference model.
    ex_q.delete(); mem_q.delete();
    for (int i = 0; i < 8; i++) begin
      int k;
      logic [31:0] a, b;
      logic [4:0] wd;
      logic wr;
      k  = $urandom_range(0, 11);
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 40));
      wd = 5'($urandom_range(0, 31));
      wr = 1'($urandom_range(0, 1));
      issue(ops[k], sels[k], a, b, wd, wr, ref_alu(ops[k], sels[k], a, b));
      clock_sb("stream");
    end
    issue(NOP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0); clock_sb("stream_drain");
    if (ex_q.size() != 0 || mem_q.size() != 1) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_level: ex_q %0d mem_q %0d", ex_q.size(), mem_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
